// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   Configurable UART transmitter. Sends one DATA_WIDTH-bit word per frame:
//   start bit, data bits LSB first, an optional parity bit, then 1 or 2 stop
//   bits. Bit timing uses a baud counter that acts as a clock enable, so the
//   whole block runs on clk.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   tx_valid_i  data_i holds a word to send
//   data_i      word to send, LSB transmitted first
//   tx_ready_o  block can accept a word this cycle (state == IDLE)
//   tx_busy_o   frame in progress (inverse of tx_ready_o)
//   tx_done_o   one-cycle pulse on the first IDLE cycle after the last stop bit
//   tx_o        serial line, idle high, registered
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  tx_ready_o,
  output logic                  tx_busy_o,
  output logic                  tx_done_o,
  output logic                  tx_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  // Elaboration-time parameter checks.
  if (CLKS_PER_BIT < 2) begin : g_err_cpb
    $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be >= 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_err_dw
    $error("uart_tx_cfg: DATA_WIDTH must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  tick;

  // Last clock of the current bit period.
  assign tick       = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_ready_o = (state == S_IDLE);
  assign tx_busy_o  = ~tx_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tx_o      <= 1'b1;
      tx_done_o <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      // Baud counter free-runs while a frame is active; wraps on tick.
      if (state != S_IDLE)
        baud_cnt <= tick ? '0 : baud_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          tx_o <= 1'b1;
          if (tx_valid_i) begin
            shreg    <= data_i;
            // Odd parity is the inverted XOR of the word.
            par_bit  <= (PARITY == 2) ^ (^data_i);
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_o     <= 1'b0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            tx_o    <= shreg[0];
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (tick) begin
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              stop_cnt <= 1'b0;
              if (PARITY != 0) begin
                tx_o  <= par_bit;
                state <= S_PARITY;
              end else begin
                tx_o  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              // Bit 0 is on the line; the next one is shreg[1] before the shift.
              tx_o    <= shreg[1];
              shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            tx_o     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= S_STOP;
          end
        end

        S_STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              tx_done_o <= 1'b1;
              state     <= S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          // Illegal encoding: park safely with the line idle.
          tx_o     <= 1'b1;
          baud_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst_n;
  logic       v   [4];
  logic [8:0] d   [4];
  logic       rdy [4];
  logic       bsy [4];
  logic       dn  [4];
  logic       tx  [4];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         k;
    logic [8:0] w;
    logic       p;
    bit         b2b;
  } exp_t;
  exp_t sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7O2 ; all CLKS_PER_BIT = 16
  uart_tx_cfg #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_valid_i(v[0]), .data_i(d[0][7:0]),
    .tx_ready_o(rdy[0]), .tx_busy_o(bsy[0]), .tx_done_o(dn[0]), .tx_o(tx[0]));
  uart_tx_cfg #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_valid_i(v[1]), .data_i(d[1][7:0]),
    .tx_ready_o(rdy[1]), .tx_busy_o(bsy[1]), .tx_done_o(dn[1]), .tx_o(tx[1]));
  uart_tx_cfg #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_valid_i(v[2]), .data_i(d[2][7:0]),
    .tx_ready_o(rdy[2]), .tx_busy_o(bsy[2]), .tx_done_o(dn[2]), .tx_o(tx[2]));
  uart_tx_cfg #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .tx_valid_i(v[3]), .data_i(d[3][6:0]),
    .tx_ready_o(rdy[3]), .tx_busy_o(bsy[3]), .tx_done_o(dn[3]), .tx_o(tx[3]));

  function automatic void chk(string nm, int act, int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  // Line monitor: decodes a frame from tx, checks every bit is held 16 clocks,
  // done arrives right after the last stop bit, then scores against the queue.
  task automatic mon(input int k, input int dw, input int par, input int sb);
    int         nb, gap;
    logic       b;
    logic [8:0] val;
    logic       pb;
    bit         stable, stop_ok, aborted, pend;
    exp_t       e;
    nb   = 1 + dw + ((par != 0) ? 1 : 0) + sb;
    gap  = 2;
    pend = 0;
    b    = 1'b1;
    forever begin
      if (!pend) @(negedge clk);
      pend = 0;
      if (!rst_n) begin gap = 2; continue; end
      if (tx[k] !== 1'b0) begin if (gap < 2) gap++; continue; end
      val = '0; pb = 1'b0; stable = 1; stop_ok = 1; aborted = 0;
      for (int bi = 0; bi < nb; bi++) begin
        for (int c = 0; c < 16; c++) begin
          if (bi != 0 || c != 0) @(negedge clk);
          if (!rst_n) begin aborted = 1; break; end
          if (c == 0) b = tx[k];
          else if (tx[k] !== b) stable = 0;
          if (rdy[k] !== 1'b0 || bsy[k] !== 1'b1 || dn[k] !== 1'b0) stable = 0;
        end
        if (aborted) break;
        if (bi == 0) ;
        else if (bi <= dw) val[bi-1] = b;
        else if (par != 0 && bi == dw + 1) pb = b;
        else if (b !== 1'b1) stop_ok = 0;
      end
      if (aborted) begin gap = 2; continue; end
      @(negedge clk);
      chk("done_pulse_and_ready", int'({dn[k], rdy[k]}), 3);
      if (sbq.size() == 0) begin
        chk("extra_frame", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("frame_instance", k, e.k);
        chk("frame_data", int'(val), int'(e.w));
        if (par != 0) chk("parity_bit", int'(pb), int'(e.p));
        chk("stop_bits_high", int'(stop_ok), 1);
        chk("bit_hold_16clk", int'(stable), 1);
        if (e.b2b) chk("b2b_start_gap", gap, 0);
      end
      gap = 0;
      @(negedge clk);
      chk("done_one_cycle", int'(dn[k]), 0);
      if (tx[k] === 1'b0) pend = 1;
      else gap = 1;
    end
  endtask

  initial mon(0, 8, 0, 1);
  initial mon(1, 8, 1, 1);
  initial mon(2, 8, 2, 1);
  initial mon(3, 7, 2, 2);

  task automatic send(input int k, input logic [8:0] w, input logic p, input bit b2b, input bit push);
    int to;
    exp_t e;
    if (push) begin
      e.k = k; e.w = w; e.p = p; e.b2b = b2b;
      sbq.push_back(e);
    end
    @(negedge clk);
    d[k] = w;
    v[k] = 1'b1;
    to = 0;
    while (rdy[k] !== 1'b1 && to < 3000) begin @(negedge clk); to++; end
    chk("accept_timeout", int'(to >= 3000), 0);
    @(posedge clk);
    @(negedge clk);
    v[k] = 1'b0;
  endtask

  task automatic drain();
    int to;
    to = 0;
    while (sbq.size() != 0 && to < 1000) begin @(negedge clk); to++; end
    chk("drain_timeout", int'(to >= 1000), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int dn_seen;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin v[k] = 1'b0; d[k] = '0; end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_tx", int'(tx[k]), 1);
      chk("reset_ready", int'(rdy[k]), 1);
      chk("reset_busy", int'(bsy[k]), 0);
      chk("reset_done", int'(dn[k]), 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frames; parity bits hand-computed.
    send(0, 9'h055, 1'b0, 0, 1); drain();
    send(1, 9'h007, 1'b1, 0, 1); drain();
    send(1, 9'h000, 1'b0, 0, 1); drain();
    send(2, 9'h007, 1'b0, 0, 1); drain();
    send(3, 9'h07F, 1'b0, 0, 1); drain();

    // Back-to-back: second word waits with valid high, starts right after done.
    send(0, 9'h0A5, 1'b0, 0, 1);
    send(0, 9'h03C, 1'b0, 1, 1);
    drain();

    // Valid/data driven mid-frame must be ignored and not queued.
    send(0, 9'h012, 1'b0, 0, 1);
    repeat (40) @(negedge clk);
    d[0] = 9'h0FF;
    v[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("ready_low_midframe", int'(rdy[0]), 0);
    repeat (30) @(negedge clk);
    v[0] = 1'b0;
    drain();
    repeat (200) @(negedge clk);
    chk("idle_after_ignored", int'(tx[0]), 1);

    // Reset during data bit 3 of 0xC3 (bit 3 = 0): frame lost.
    send(0, 9'h0C3, 1'b0, 0, 0);
    repeat (70) @(negedge clk);
    chk("pre_reset_bit3", int'(tx[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx[0]), 1);
    chk("midrst_ready", int'(rdy[0]), 1);
    chk("midrst_busy", int'(bsy[0]), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    dn_seen = 0;
    repeat (200) begin @(negedge clk); if (dn[0] === 1'b1) dn_seen++; end
    chk("no_done_after_reset", dn_seen, 0);
    send(0, 9'h081, 1'b0, 0, 1); drain();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
